fb_pixel_writer: RTL
====================

// Module: fb_pixel_writer
// PURPOSE
//  Consumes the pixel stream of the line/triangle drawing engines (x, y, drawing) and turns it
//  into framebuffer write requests. Clips each pixel to the framebuffer, computes a linear
//  address, and buffers requests for a memory port that may stall. Throttles the engine via oe.
// PARAMETERS
//  CORDW       16   signed coordinate width, matching the drawing engines
//  FB_WIDTH    320  framebuffer width in pixels
//  FB_HEIGHT   180  framebuffer height in pixels
//  COLRW       4    colour width in bits
//  FIFO_DEPTH  4    request FIFO entries; power of two, minimum 4
//  ADDRW       $clog2(FB_WIDTH*FB_HEIGHT)  address width (derived, do not override)
// PORTS
//  clk        in   1      clock
//  rst        in   1      synchronous reset, active high
//  x, y       in   CORDW  signed pixel position from the drawing engine
//  drawing    in   1      pixel valid this cycle (engine only asserts when oe=1)
//  colr       in   COLRW  pixel colour, sampled with drawing
//  oe         out  1      output enable to the engine; registered
//  fb_ready   in   1      memory port accepts a write this cycle
//  fb_we      out  1      write request valid
//  fb_addr    out  ADDRW  linear address: y*FB_WIDTH + x
//  fb_colr    out  COLRW  write data
//  busy       out  1      any pixel in the pipeline or FIFO
//  clip_cnt   out  16     clipped-pixel count (FB_WRITER_CLIP_CNT_EN only)
// BEHAVIOUR
//  - Reset: oe=0, fb_we=0, fb_addr=0, fb_colr=0, busy=0, clip_cnt=0.
//    Pipeline valids and the FIFO are cleared. oe rises the cycle after rst falls.
//  - Reset mid-operation drops all in-flight pixels. Nothing is written after the rst cycle.
//  - S1 (drawing=1): register x, y, colr. Clip if x<0, x>=FB_WIDTH, y<0 or y>=FB_HEIGHT.
//    A clipped pixel is invalid from S2 on and is never written.
//  - S2: fb_addr = y*FB_WIDTH + x, computed unsigned at ADDRW bits after the clip check.
//    Registered, then pushed into the FIFO.
//  - S1 and S2 never stall. Latency is drawing to fb_we = 3 cycles when the FIFO is empty.
//  - FIFO: first-word fall-through. fb_we = !empty, and fb_addr/fb_colr show the head entry.
//    Pop on fb_we && fb_ready. A simultaneous push and pop leaves the count unchanged.
//  - Flow control: occ = fifo count + S1 valid + S2 valid (next-state values).
//    oe <= (occ_next < FIFO_DEPTH). This guarantees no overflow with the one-cycle oe lag.
//    Overflow is an assertion failure.
//  - fb_we/fb_addr/fb_colr stay stable while fb_we=1 && fb_ready=0.
//  - Full throughput: with fb_ready held 1, oe stays 1 and one pixel is written per cycle.
//  - busy = S1 valid | S2 valid | !empty.
// CONFIGURATION
//  FB_WRITER_CLIP_CNT_EN defined: clip_cnt adds 1 per clipped pixel, saturates at 16'hFFFF,
//   and clears on rst.
//  Not defined: clip_cnt port is absent and there is no counter logic.
// STRUCTURE
//  Package fb_pkg: typedef fb_req_t {addr, colr}; constant FB_FIFO_MIN_DEPTH=4.
//  Sub-module fb_req_fifo: synchronous FWFT FIFO of fb_req_t, with count output.
//   Instanced once. Clip and address pipeline stay in this module.
// TESTING
//  1 Reset: after rst, oe=1 next cycle. fb_we=0, busy=0.
//  2 Single pixel (10,2), colr=5, fb_ready=1 -> fb_we 3 cycles later,
//    fb_addr=650, fb_colr=5, busy then falls.
//  3 Clipping: pixels (-1,0), (320,0), (0,180), (319,179) -> only addr 57599 written.
//    With FB_WRITER_CLIP_CNT_EN, clip_cnt=3.
//  4 Backpressure: 20-pixel stream with fb_ready=0 -> oe falls, no overflow,
//    4 requests held stable. Release fb_ready -> all 20 written in order.
//  5 Throughput: 64-pixel line, fb_ready=1 -> 64 consecutive fb_we cycles, oe never falls.
//  6 rst mid-stream with 3 pixels buffered -> no fb_we after the rst cycle.
//    The next pixel is written correctly.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types and constants for the framebuffer pixel writer.
package fb_pkg;
  localparam int FB_FIFO_MIN_DEPTH = 4;
  localparam int FB_DEF_ADDRW      = 16;
  localparam int FB_DEF_COLRW      = 4;

  // Request layout for the default 320x180, 4-bit colour framebuffer.
  typedef struct packed {
    logic [FB_DEF_ADDRW-1:0] addr;
    logic [FB_DEF_COLRW-1:0] colr;
  } fb_req_t;
endpackage

// File: rtl/fb_pixel_writer_if.sv
// Framebuffer write port: the writer is master, the memory port is slave.
interface fb_pixel_writer_if #(
  parameter int ADDRW = 16,
  parameter int COLRW = 4
);
  logic             fb_we;
  logic             fb_ready;
  logic [ADDRW-1:0] fb_addr;
  logic [COLRW-1:0] fb_colr;

  modport master (output fb_we, fb_addr, fb_colr, input fb_ready);
  modport slave  (input fb_we, fb_addr, fb_colr, output fb_ready);
endinterface

// File: rtl/fb_req_fifo.sv
// First-word fall-through request FIFO with occupancy count output.
module fb_req_fifo
  import fb_pkg::*;
#(
  parameter type req_t = fb_req_t,
  parameter int  DEPTH = FB_FIFO_MIN_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  req_t                     din,
  input  logic                     pop,
  output req_t                     head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  req_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          full, do_pop, do_push;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is legal only when the head leaves the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr_reg];
  assign count   = count_reg;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      assert (!(push && full && !do_pop));
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/fb_pixel_writer.sv
// Clips drawing-engine pixels, forms linear addresses and queues framebuffer writes.
// Optional clipped-pixel counter enabled by defining FB_WRITER_CLIP_CNT_EN.
module fb_pixel_writer
  import fb_pkg::*;
#(
  parameter int  CORDW      = 16,
  parameter int  FB_WIDTH   = 320,
  parameter int  FB_HEIGHT  = 180,
  parameter int  COLRW      = 4,
  parameter int  FIFO_DEPTH = 4,
  localparam int ADDRW      = $clog2(FB_WIDTH*FB_HEIGHT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [CORDW-1:0] x,
  input  logic signed [CORDW-1:0] y,
  input  logic                    drawing,
  input  logic [COLRW-1:0]        colr,
  output logic                    oe,
  output logic                    busy,
`ifdef FB_WRITER_CLIP_CNT_EN
  output logic [15:0]             clip_cnt,
`endif
  fb_pixel_writer_if.master       fb
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int OW = CW + 1;
  localparam logic signed [CORDW-1:0] W_S = CORDW'(FB_WIDTH);
  localparam logic signed [CORDW-1:0] H_S = CORDW'(FB_HEIGHT);

  if (FIFO_DEPTH < FB_FIFO_MIN_DEPTH || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
    $error("FIFO_DEPTH must be a power of two and at least 4");
  end

  typedef struct packed {
    logic [ADDRW-1:0] addr;
    logic [COLRW-1:0] colr;
  } req_t;

  logic                    s1_valid_reg, s2_valid_reg, oe_reg;
  logic signed [CORDW-1:0] s1_x_reg, s1_y_reg;
  logic [COLRW-1:0]        s1_colr_reg;
  req_t                    s2_req_reg, head;
  logic                    s1_clip, s2_valid_next, fifo_empty, pop;
  logic [ADDRW-1:0]        s1_addr;
  logic [CW-1:0]           fifo_count;
  logic [OW-1:0]           occ_next;

  assign s1_clip = s1_x_reg[CORDW-1] || s1_y_reg[CORDW-1] ||
                   (s1_x_reg >= W_S) || (s1_y_reg >= H_S);
  assign s1_addr = ADDRW'($unsigned(s1_y_reg)) * ADDRW'(FB_WIDTH) + ADDRW'($unsigned(s1_x_reg));
  assign s2_valid_next = s1_valid_reg && !s1_clip;
  assign pop = fb.fb_ready && !fifo_empty;

  // Everything that will be in flight next cycle; oe lags one cycle, so the
  // engine may add at most one pixel after this reaches FIFO_DEPTH.
  assign occ_next = OW'(fifo_count) + OW'(s2_valid_reg) + OW'(drawing)
                  + OW'(s2_valid_next) - OW'(pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
      oe_reg       <= 1'b0;
    end else begin
      s1_valid_reg <= drawing;
      s2_valid_reg <= s2_valid_next;
      oe_reg       <= (occ_next < OW'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    s1_x_reg    <= x;
    s1_y_reg    <= y;
    s1_colr_reg <= colr;
    s2_req_reg  <= '{addr: s1_addr, colr: s1_colr_reg};
  end

  fb_req_fifo #(
    .req_t (req_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s2_valid_reg),
    .din   (s2_req_reg),
    .pop   (pop),
    .head  (head),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign oe         = oe_reg;
  assign busy       = s1_valid_reg || s2_valid_reg || !fifo_empty;
  assign fb.fb_we   = !fifo_empty;
  assign fb.fb_addr = fifo_empty ? '0 : head.addr;
  assign fb.fb_colr = fifo_empty ? '0 : head.colr;

`ifdef FB_WRITER_CLIP_CNT_EN
  logic [15:0] clip_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      clip_cnt_reg <= '0;
    end else if (s1_valid_reg && s1_clip && clip_cnt_reg != 16'hFFFF) begin
      clip_cnt_reg <= clip_cnt_reg + 16'd1;
    end
  end

  assign clip_cnt = clip_cnt_reg;
`endif
endmodule
